resetn_seq: RTL and testbench
=============================

RESETN_SEQ -- requirements
Module: resetn_seq

Interface
REQ-001 SHALL have parameter NCH, default 128: number of reset channels, a multiple of 32, range 32..128.
REQ-002 SHALL have parameter CNTW, default 16: width of the hold and stagger counters.
REQ-003 SHALL have parameter POR_HOLD, default 64: hold cycles of the automatic sequence after reset.
REQ-004 SHALL have parameter ADDR_WIDTH, default 8; data width is fixed at 32.
REQ-005 SHALL have port clk, input, 1 bit: the single clock for all logic.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port wren, input, 1 bit: local-bus write strobe.
REQ-008 SHALL have port waddr, input, ADDR_WIDTH bits: write address.
REQ-009 SHALL have port wdata, input, 32 bits: write data.
REQ-010 SHALL have port rden, input, 1 bit: read strobe.
REQ-011 SHALL have port raddr, input, ADDR_WIDTH bits: read address.
REQ-012 SHALL have port rdata, output, 32 bits: read data.
REQ-013 SHALL have port rvalid, output, 1 bit: read data valid.
REQ-014 SHALL have port resetn, output, NCH bits: active-low channel resets.
REQ-015 SHALL have port busy, output, 1 bit: sequencer is not in IDLE.

Function
REQ-016 SHALL use this register map: 0x00..0x03 MASK words (word k = channels 32k..32k+31, only NCH/32 words exist), 0x10 HOLD (CNTW bits), 0x11 STAGGER (CNTW bits), 0x12 CTRL (bit0 start, self-clearing; bit1 mode: 0 = simultaneous, 1 = staggered), 0x13 STATUS (bit0 busy, bit1 done sticky, bit2 overrun sticky), 0x14 write-1-to-clear for STATUS[2:1].
REQ-017 SHALL return rdata and rvalid exactly 1 cycle after rden; unmapped or absent addresses SHALL read 0.
REQ-018 SHALL implement FSM states IDLE, ASSERT, RELEASE and DONE.
REQ-019 SHALL move from IDLE to ASSERT on a CTRL write with bit0=1, latching MASK, HOLD, STAGGER and mode at that cycle.
REQ-020 SHALL drive resetn low for masked channels on the cycle after entering ASSERT and hold it low for max(HOLD,1) cycles, then go to RELEASE.
REQ-021 In simultaneous mode, RELEASE SHALL drive all masked channels high in one cycle, then go to DONE.
REQ-022 In staggered mode, RELEASE SHALL drive masked channels high one at a time in ascending index order, max(STAGGER,1) cycles apart, skipping unmasked channels with no idle cycles; after the last channel it SHALL go to DONE.
REQ-023 With an all-zero latched mask, the sequencer SHALL pass through ASSERT and RELEASE with no output change and still set done.
REQ-024 DONE SHALL set STATUS done and return to IDLE in 1 cycle.
REQ-025 Unmasked channels SHALL keep their current level throughout a sequence.
REQ-026 A start while busy SHALL be ignored and SHALL set overrun; a later start from IDLE SHALL work normally.
REQ-027 Register writes during a sequence SHALL update the registers but SHALL NOT affect the running sequence.
REQ-028 HOLD and STAGGER counters SHALL compare full CNTW-bit values and SHALL NOT wrap; 2^CNTW-1 is a legal value.

Reset
REQ-029 While reset=1, the block SHALL drive resetn all 0, busy 0, rvalid 0 and rdata 0, set MASK all ones, HOLD=POR_HOLD, STAGGER=0 and CTRL=0, and clear STATUS.
REQ-030 On the first cycle after reset falls, the block SHALL start an automatic simultaneous sequence on all channels with POR_HOLD hold.
REQ-031 Reset asserted mid-sequence SHALL abort the sequence immediately and apply REQ-029.

Verification
REQ-032 Release reset, NCH=128, POR_HOLD=64 -> resetn=0 for 64 cycles after entering ASSERT, then all 1 in one cycle; STATUS=0x2.
REQ-033 Write MASK0=0x5, HOLD=10, STAGGER=3, CTRL=0x3 -> channels 0 and 2 go low for 10 cycles; ch0 rises, ch2 rises 3 cycles later; all other channels stay 1.
REQ-034 Write CTRL=0x1 again during ASSERT -> no effect on the running sequence, STATUS[2]=1; write 0x4 to 0x14 -> STATUS[2]=0.
REQ-035 Assert reset during staggered RELEASE -> resetn=0 on the next edge and the POR sequence follows.
REQ-036 Read 0x13 while busy -> rvalid 1 cycle after rden, rdata bit0=1; read 0x03 with NCH=32 -> rdata 0.

Source files
------------

// File: rtl/resetn_seq.sv
// Reset sequencer: drives NCH active-low channel resets through a
// hold / release sequence configured over a simple local register bus.
// An automatic simultaneous sequence on every channel follows each reset.
module resetn_seq #(
  parameter int unsigned NCH        = 128,
  parameter int unsigned CNTW       = 16,
  parameter int unsigned POR_HOLD   = 64,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wren,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [31:0]           wdata,
  input  logic                  rden,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [31:0]           rdata,
  output logic                  rvalid,
  output logic [NCH-1:0]        resetn,
  output logic                  busy
);

  localparam int unsigned NWORDS = NCH / 32;

  localparam logic [ADDR_WIDTH-1:0] A_HOLD   = ADDR_WIDTH'(8'h10);
  localparam logic [ADDR_WIDTH-1:0] A_STAG   = ADDR_WIDTH'(8'h11);
  localparam logic [ADDR_WIDTH-1:0] A_CTRL   = ADDR_WIDTH'(8'h12);
  localparam logic [ADDR_WIDTH-1:0] A_STATUS = ADDR_WIDTH'(8'h13);
  localparam logic [ADDR_WIDTH-1:0] A_CLR    = ADDR_WIDTH'(8'h14);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    RELEASE = 2'd2,
    DONE    = 2'd3
  } state_t;

  // Software-visible registers
  logic [31:0]     mask_q [NWORDS];
  logic [NCH-1:0]  mask_flat;
  logic [CNTW-1:0] hold_q;
  logic [CNTW-1:0] stag_q;
  logic            mode_q;
  logic            done_q;
  logic            ovr_q;
  logic            por_q;

  // Sequencer state and the snapshot taken at start
  state_t          state;
  state_t          state_nx;
  logic [CNTW-1:0] cnt;
  logic [CNTW-1:0] cnt_nx;
  logic [NCH-1:0]  pend;
  logic [NCH-1:0]  low_bit;
  logic [CNTW-1:0] seq_hold;
  logic [CNTW-1:0] seq_stag;
  logic            seq_mode;
  logic [CNTW-1:0] hold_m1;
  logic [CNTW-1:0] stag_m1;

  // FSM commands to the datapath
  logic load_por;
  logic load_sw;
  logic do_assert;
  logic do_rel_all;
  logic do_rel_one;
  logic done_set;
  logic ovr_set;
  logic start_wr;
  logic clr_wr;

  logic [31:0] rd_val;

  assign start_wr = wren && (waddr == A_CTRL) && wdata[0];
  assign clr_wr   = wren && (waddr == A_CLR);

  // Zero hold/stagger behave as one cycle; terminal counts never wrap
  assign hold_m1 = (seq_hold == '0) ? '0 : seq_hold - CNTW'(1);
  assign stag_m1 = (seq_stag == '0) ? '0 : seq_stag - CNTW'(1);

  // Lowest still-pending channel: next one to release in staggered mode
  assign low_bit = pend & (~pend + NCH'(1));

  // Start while a sequence runs (or the POR sequence is being launched) is dropped
  assign ovr_set = start_wr && ((state != IDLE) || por_q);

  // Flatten mask words into a channel vector
  always_comb begin
    mask_flat = '0;
    for (int unsigned k = 0; k < NWORDS; k++) begin
      mask_flat[k*32 +: 32] = mask_q[k];
    end
  end

  // State register and hold/stagger counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      busy  <= (state_nx != IDLE);
    end
  end

  // Next-state and sequencing commands
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    load_por   = 1'b0;
    load_sw    = 1'b0;
    do_assert  = 1'b0;
    do_rel_all = 1'b0;
    do_rel_one = 1'b0;
    done_set   = 1'b0;
    case (state)
      IDLE: begin
        if (por_q) begin
          state_nx = ASSERT;
          cnt_nx   = '0;
          load_por = 1'b1;
        end else if (start_wr) begin
          state_nx = ASSERT;
          cnt_nx   = '0;
          load_sw  = 1'b1;
        end
      end
      ASSERT: begin
        do_assert = (cnt == '0);
        if (cnt == hold_m1) begin
          state_nx = RELEASE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CNTW'(1);
        end
      end
      RELEASE: begin
        if (!seq_mode) begin
          do_rel_all = 1'b1;
          state_nx   = DONE;
        end else if (pend == '0) begin
          state_nx = DONE;
        end else begin
          do_rel_one = (cnt == '0);
          if ((cnt == '0) && ((pend & ~low_bit) == '0)) begin
            state_nx = DONE;
            cnt_nx   = '0;
          end else if (cnt == stag_m1) begin
            cnt_nx = '0;
          end else begin
            cnt_nx = cnt + CNTW'(1);
          end
        end
      end
      DONE: begin
        done_set = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Sequence snapshot and channel reset outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      resetn   <= '0;
      pend     <= '0;
      seq_hold <= '0;
      seq_stag <= '0;
      seq_mode <= 1'b0;
    end else begin
      if (load_por) begin
        pend     <= '1;
        seq_hold <= CNTW'(POR_HOLD);
        seq_stag <= '0;
        seq_mode <= 1'b0;
      end else if (load_sw) begin
        pend     <= mask_flat;
        seq_hold <= hold_q;
        seq_stag <= stag_q;
        seq_mode <= wdata[1];
      end
      if (do_assert) begin
        resetn <= resetn & ~pend;
      end else if (do_rel_all) begin
        resetn <= resetn | pend;
      end else if (do_rel_one) begin
        resetn <= resetn | low_bit;
        pend   <= pend & ~low_bit;
      end
    end
  end

  // Configuration and sticky status registers
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned k = 0; k < NWORDS; k++) begin
        mask_q[k] <= '1;
      end
      hold_q <= CNTW'(POR_HOLD);
      stag_q <= '0;
      mode_q <= 1'b0;
      done_q <= 1'b0;
      ovr_q  <= 1'b0;
      por_q  <= 1'b1;
    end else begin
      por_q <= 1'b0;
      if (wren) begin
        for (int unsigned k = 0; k < NWORDS; k++) begin
          if (waddr == ADDR_WIDTH'(k)) begin
            mask_q[k] <= wdata;
          end
        end
        if (waddr == A_HOLD) hold_q <= wdata[CNTW-1:0];
        if (waddr == A_STAG) stag_q <= wdata[CNTW-1:0];
        if (waddr == A_CTRL) mode_q <= wdata[1];
      end
      done_q <= (done_q & ~(clr_wr & wdata[1])) | done_set;
      ovr_q  <= (ovr_q  & ~(clr_wr & wdata[2])) | ovr_set;
    end
  end

  // Read decode; absent mask words and unmapped addresses read zero
  always_comb begin
    rd_val = '0;
    for (int unsigned k = 0; k < NWORDS; k++) begin
      if (raddr == ADDR_WIDTH'(k)) begin
        rd_val = mask_q[k];
      end
    end
    if (raddr == A_HOLD) begin
      rd_val = 32'(hold_q);
    end else if (raddr == A_STAG) begin
      rd_val = 32'(stag_q);
    end else if (raddr == A_CTRL) begin
      rd_val = {30'd0, mode_q, 1'b0};
    end else if (raddr == A_STATUS) begin
      rd_val = {29'd0, ovr_q, done_q, busy};
    end
  end

  // Registered read response, one cycle after rden
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= rden;
      rdata  <= rden ? rd_val : '0;
    end
  end

endmodule

// File: tb/tb_resetn_seq.sv
// Self-checking bench for resetn_seq: a per-edge behavioural model built from
// per-channel release times drives the expectations for both DUT instances.
module tb_resetn_seq;

  localparam int NCH = 128;
  localparam int POR_HOLD = 64;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          wren;
  logic [AW-1:0] waddr;
  logic [31:0]   wdata;
  logic          rden;
  logic [AW-1:0] raddr;
  logic [31:0]   rdata;
  logic          rvalid;
  logic [127:0]  resetn;
  logic          busy;
  logic [31:0]   rdata32;
  logic          rvalid32;
  logic [31:0]   resetn32;
  logic          busy32;

  always #5 clk = ~clk;

  resetn_seq #(.NCH(NCH), .CNTW(16), .POR_HOLD(POR_HOLD), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .wren(wren), .waddr(waddr), .wdata(wdata),
    .rden(rden), .raddr(raddr), .rdata(rdata), .rvalid(rvalid),
    .resetn(resetn), .busy(busy)
  );

  resetn_seq #(.NCH(32), .CNTW(16), .POR_HOLD(POR_HOLD), .ADDR_WIDTH(AW)) dut32 (
    .clk(clk), .reset(reset), .wren(wren), .waddr(waddr), .wdata(wdata),
    .rden(rden), .raddr(raddr), .rdata(rdata32), .rvalid(rvalid32),
    .resetn(resetn32), .busy(busy32)
  );

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  // Reference model state
  logic [127:0] m_rn;
  logic [127:0] m_mask;
  bit           m_active, m_done, m_ovr, por_next;
  int           m_t0, m_end;
  int           rise [128];
  logic [31:0]  mw [4];
  int           r_hold, r_stag;
  bit           r_mode;
  logic [31:0]  e_rdata, e_rdata32;
  bit           e_rvalid, e_chk32;

  logic [7:0] alist [10] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h20};

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Per-channel release schedule for a sequence sampled at edge t0
  task automatic start_model(input int t0, input logic [127:0] mask, input int hold,
                             input int stag, input bit mode);
    int h, s, j;
    h = (hold == 0) ? 1 : hold;
    s = (stag == 0) ? 1 : stag;
    j = 0;
    for (int c = 0; c < 128; c++) begin
      if (mask[c]) begin
        rise[c] = mode ? (t0 + 1 + h + j * s) : (t0 + 1 + h);
        j++;
      end
    end
    m_end    = t0 + h + 2 + ((mode && j > 1) ? (j - 1) * s : 0);
    m_t0     = t0;
    m_mask   = mask;
    m_active = 1'b1;
  endtask

  function automatic logic [31:0] read_model(input logic [7:0] a);
    if (a < 8'd4)   return mw[a[1:0]];
    if (a == 8'h10) return 32'(r_hold);
    if (a == 8'h11) return 32'(r_stag);
    if (a == 8'h12) return {30'd0, r_mode, 1'b0};
    if (a == 8'h13) return {29'd0, m_ovr, m_done, m_active};
    return 32'd0;
  endfunction

  // Advance the model across one active clock edge using the sampled inputs
  task automatic model_edge();
    bit start, was_active;
    logic [127:0] cur_mask;
    if (reset) begin
      m_rn = '0; m_active = 0; m_done = 0; m_ovr = 0; por_next = 1;
      for (int k = 0; k < 4; k++) mw[k] = '1;
      r_hold = POR_HOLD; r_stag = 0; r_mode = 0;
      e_rvalid = 0; e_chk32 = 0;
      return;
    end
    e_rvalid = rden;
    e_chk32  = 0;
    if (rden) begin
      e_rdata   = read_model(raddr);
      e_chk32   = (raddr < 8'd4) || (raddr == 8'h10) || (raddr == 8'h11);
      e_rdata32 = (raddr == 8'h00) ? mw[0] : ((raddr < 8'd4) ? 32'd0 : read_model(raddr));
    end
    start      = wren && (waddr == 8'h12) && wdata[0];
    was_active = m_active;
    cur_mask   = {mw[3], mw[2], mw[1], mw[0]};
    if (was_active) begin
      if (edge_n == m_t0 + 1) m_rn = m_rn & ~m_mask;
      for (int c = 0; c < 128; c++)
        if (m_mask[c] && rise[c] == edge_n) m_rn[c] = 1'b1;
    end
    if (start && (was_active || por_next)) m_ovr = 1;
    if (wren) begin
      if (waddr < 8'd4)   mw[waddr[1:0]] = wdata;
      if (waddr == 8'h10) r_hold = int'(wdata[15:0]);
      if (waddr == 8'h11) r_stag = int'(wdata[15:0]);
      if (waddr == 8'h12) r_mode = wdata[1];
      if (waddr == 8'h14) begin
        if (wdata[1]) m_done = 0;
        if (wdata[2]) m_ovr = 0;
      end
    end
    if (was_active && edge_n == m_end) begin
      m_active = 0;
      m_done   = 1;
    end
    if (por_next) begin
      start_model(edge_n, '1, POR_HOLD, 0, 1'b0);
      por_next = 0;
    end else if (start && !was_active) begin
      start_model(edge_n, cur_mask, r_hold, r_stag, wdata[1]);
    end
  endtask

  // One clock: model update at the edge, compare on the falling edge
  task automatic tick();
    @(posedge clk);
    edge_n++;
    model_edge();
    @(negedge clk);
    chk("resetn", resetn, m_rn);
    chk("resetn32", 128'(resetn32), 128'(m_rn[31:0]));
    chk("busy", 128'(busy), 128'(m_active));
    chk("rvalid", 128'(rvalid), 128'(e_rvalid));
    chk("rvalid32", 128'(rvalid32), 128'(e_rvalid));
    if (e_rvalid) chk("rdata", 128'(rdata), 128'(e_rdata));
    if (e_rvalid && e_chk32) chk("rdata32", 128'(rdata32), 128'(e_rdata32));
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    wren = 1'b1; waddr = a; wdata = d;
    tick();
    wren = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a);
    rden = 1'b1; raddr = a;
    tick();
    rden = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((m_active || por_next) && n < 20000) begin
      tick();
      n++;
    end
    chk("busy32_idle", 128'(busy32), 128'(0));
  endtask

  initial begin
    int n;
    logic [31:0] w;
    reset = 1'b1; wren = 1'b0; rden = 1'b0;
    waddr = '0; raddr = '0; wdata = '0;

    // Reset state, then the automatic power-on sequence
    repeat (3) tick();
    reset = 1'b0;
    wait_idle();
    rd(8'h13);
    rd(8'h03);
    rd(8'h00);
    rd(8'h10);

    // Staggered sequence on channels 0 and 2 with overrun during ASSERT
    wr(8'h00, 32'h5); wr(8'h01, 32'h0); wr(8'h02, 32'h0); wr(8'h03, 32'h0);
    wr(8'h10, 32'd10); wr(8'h11, 32'd3);
    wr(8'h12, 32'h3);
    tick();
    rd(8'h13);
    wr(8'h12, 32'h1);
    rd(8'h13);
    wait_idle();
    rd(8'h13);
    wr(8'h14, 32'h4);
    rd(8'h13);
    wr(8'h14, 32'h2);
    rd(8'h13);
    rd(8'h12);

    // Randomized sequences, including zero mask and zero hold/stagger
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 4; k++) begin
        w = ($urandom_range(0, 2) != 0) ? ($urandom & $urandom & $urandom) : 32'd0;
        if (r == 0) w = 32'd0;
        wr(8'(k), w);
      end
      wr(8'h10, (r == 1) ? 32'd0 : 32'($urandom_range(0, 6)));
      wr(8'h11, (r == 1) ? 32'd0 : 32'($urandom_range(0, 4)));
      wr(8'h12, {30'd0, 1'((r % 2) == 1), 1'b1});
      n = 0;
      while (m_active && n < 20000) begin
        if ($urandom_range(0, 3) == 0) begin
          rden = 1'b1;
          raddr = alist[$urandom_range(0, 9)];
        end
        if ($urandom_range(0, 7) == 0) begin
          wren = 1'b1;
          waddr = 8'h10;
          wdata = 32'($urandom_range(0, 9));
        end
        tick();
        rden = 1'b0;
        wren = 1'b0;
        n++;
      end
      wait_idle();
      rd(8'h13);
    end

    // Reset during staggered release aborts and re-runs the POR sequence
    wr(8'h00, 32'h0000_0F0F); wr(8'h01, 32'h0); wr(8'h02, 32'h0); wr(8'h03, 32'h0);
    wr(8'h10, 32'd2); wr(8'h11, 32'd3);
    wr(8'h12, 32'h3);
    n = 0;
    while (edge_n < m_t0 + 7 && n < 100) begin
      tick();
      n++;
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wait_idle();
    rd(8'h13);
    rd(8'h00);
    rd(8'h20);
    rd(8'h14);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
